// File: rtl/prim_lfsr_bank.sv
// -----------------------------------------------------------------------------
// prim_lfsr_bank
//
// Multi-channel Galois-XOR pseudo-random generator. All channels share one tap
// mask and one seeding interface. An autonomous two-state FSM (RESEED / RUN)
// requests one seed per channel and then generates words into a valid/ready
// output register. It returns to RESEED on a step-count interval or on request.
// An all-zero channel state is replaced by DefaultSeed and flagged on lockup_o.
//
// Optional feature: when the macro PRIM_LFSR_BANK_SBOX_OUT_EN is defined, each
// output nibble is passed through the PRINCE 4-bit S-box. The output register
// latency is the same in both builds.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   seed_req_o      seed wanted for channel seed_idx_o
//   seed_idx_o      channel being seeded
//   seed_ack_i      seed_i valid (consumed only while seed_req_o=1)
//   seed_i          seed value
//   reseed_req_i    single-cycle full reseed request (honoured in RUN)
//   en_i            generation enable
//   entropy_valid_i XOR entropy_i into this step
//   entropy_i       extra entropy applied to every channel
//   out_valid_o     out_data_o holds an unconsumed word
//   out_ready_i     consumer accepts the word
//   out_data_o      channel c at [c*StateOutDw +: StateOutDw]
//   lockup_o        one-cycle pulse per channel recovered from all-zero
// -----------------------------------------------------------------------------
module prim_lfsr_bank #(
    parameter int unsigned       NumCh          = 4,
    parameter int unsigned       LfsrDw         = 32,
    parameter int unsigned       StateOutDw     = 8,
    parameter logic [LfsrDw-1:0] Coeffs         = 32'h80200003,
    parameter logic [LfsrDw-1:0] DefaultSeed    = {{(LfsrDw-1){1'b0}}, 1'b1},
    parameter int unsigned       ReseedInterval = 1024
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    output logic                                        seed_req_o,
    output logic [((NumCh > 1) ? $clog2(NumCh) : 1)-1:0] seed_idx_o,
    input  logic                                        seed_ack_i,
    input  logic [LfsrDw-1:0]                           seed_i,
    input  logic                                        reseed_req_i,
    input  logic                                        en_i,
    input  logic                                        entropy_valid_i,
    input  logic [LfsrDw-1:0]                           entropy_i,
    output logic                                        out_valid_o,
    input  logic                                        out_ready_i,
    output logic [NumCh*StateOutDw-1:0]                 out_data_o,
    output logic [NumCh-1:0]                            lockup_o
);

    localparam int unsigned IdxW  = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int unsigned CntW  = (ReseedInterval > 0) ? $clog2(ReseedInterval + 1) : 1;
    localparam int unsigned OutDw = NumCh * StateOutDw;

    typedef enum logic [0:0] {
        StReseed = 1'b0,
        StRun    = 1'b1
    } state_e;

`ifdef PRIM_LFSR_BANK_SBOX_OUT_EN
    // PRINCE 4-bit S-box.
    function automatic logic [3:0] prince_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hB;
            4'h1:    y = 4'hF;
            4'h2:    y = 4'h3;
            4'h3:    y = 4'h2;
            4'h4:    y = 4'hA;
            4'h5:    y = 4'hC;
            4'h6:    y = 4'h9;
            4'h7:    y = 4'h1;
            4'h8:    y = 4'h6;
            4'h9:    y = 4'h7;
            4'hA:    y = 4'h8;
            4'hB:    y = 4'h0;
            4'hC:    y = 4'hE;
            4'hD:    y = 4'h5;
            4'hE:    y = 4'hD;
            4'hF:    y = 4'h4;
            default: y = 4'h0;
        endcase
        return y;
    endfunction
`endif

    // Output mapping applied to the low state bits of a channel.
    function automatic logic [StateOutDw-1:0] out_map(input logic [StateOutDw-1:0] s);
        logic [StateOutDw-1:0] r;
        r = s;
`ifdef PRIM_LFSR_BANK_SBOX_OUT_EN
        for (int n = 0; n < int'(StateOutDw / 4); n++) begin
            r[4*n +: 4] = prince_sbox(s[4*n +: 4]);
        end
`endif
        return r;
    endfunction

    state_e              fsm_r;
    logic [IdxW-1:0]     idx_r;
    logic                seed_req_r;
    logic [CntW-1:0]     cnt_r;
    logic [LfsrDw-1:0]   state_r [NumCh];
    logic                out_valid_r;
    logic [OutDw-1:0]    out_data_r;
    logic [NumCh-1:0]    lockup_r;

    logic [LfsrDw-1:0]   step_val_s [NumCh];
    logic [NumCh-1:0]    step_zero_s;
    logic [NumCh-1:0]    seed_sel_s;
    logic [NumCh-1:0]    lockup_next_s;
    logic [OutDw-1:0]    out_next_s;
    logic [CntW-1:0]     cnt_inc_s;
    logic                step_s;
    logic                seed_load_s;
    logic                seed_zero_s;
    logic                last_idx_s;
    logic                cnt_hit_s;
    logic                go_reseed_s;

    // Per-channel Galois step with entropy, zero-state recovery and output mapping.
    always_comb begin
        step_zero_s = {NumCh{1'b0}};
        out_next_s  = {OutDw{1'b0}};
        for (int c = 0; c < int'(NumCh); c++) begin
            logic [LfsrDw-1:0] nxt;
            nxt = (state_r[c] >> 1) ^ ({LfsrDw{state_r[c][0]}} & Coeffs)
                  ^ (entropy_valid_i ? entropy_i : {LfsrDw{1'b0}});
            step_zero_s[c] = (nxt == {LfsrDw{1'b0}});
            if (step_zero_s[c]) begin
                step_val_s[c] = DefaultSeed;
            end else begin
                step_val_s[c] = nxt;
            end
            out_next_s[c*StateOutDw +: StateOutDw] = out_map(step_val_s[c][StateOutDw-1:0]);
        end
    end

    // Handshake, step and reseed decisions.
    always_comb begin
        step_s      = (fsm_r == StRun) && en_i && (!out_valid_r || out_ready_i);
        seed_load_s = (fsm_r == StReseed) && seed_ack_i;
        seed_zero_s = (seed_i == {LfsrDw{1'b0}});
        last_idx_s  = (idx_r == IdxW'(NumCh - 1));
        cnt_inc_s   = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
        // A zero interval disables the periodic reseed entirely.
        cnt_hit_s   = (ReseedInterval != 32'd0) && (32'(cnt_inc_s) == ReseedInterval);
        go_reseed_s = (fsm_r == StRun) && (reseed_req_i || (step_s && cnt_hit_s));
        for (int c = 0; c < int'(NumCh); c++) begin
            seed_sel_s[c] = seed_load_s && (idx_r == IdxW'(c));
        end
    end

    // Lockup flags for the coming cycle: from a step, or from a zero seed.
    always_comb begin
        lockup_next_s = {NumCh{1'b0}};
        if (step_s) begin
            lockup_next_s = step_zero_s;
        end else if (seed_zero_s) begin
            lockup_next_s = seed_sel_s;
        end else begin
            lockup_next_s = {NumCh{1'b0}};
        end
    end

    // Seeding / run FSM with seed index, step counter and registered seed request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_r      <= StReseed;
            idx_r      <= {IdxW{1'b0}};
            seed_req_r <= 1'b1;
            cnt_r      <= {CntW{1'b0}};
        end else begin
            case (fsm_r)
                StReseed: begin
                    if (seed_ack_i) begin
                        if (last_idx_s) begin
                            fsm_r      <= StRun;
                            idx_r      <= {IdxW{1'b0}};
                            seed_req_r <= 1'b0;
                        end else begin
                            idx_r <= idx_r + {{(IdxW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                StRun: begin
                    if (go_reseed_s) begin
                        fsm_r      <= StReseed;
                        seed_req_r <= 1'b1;
                        cnt_r      <= {CntW{1'b0}};
                    end else if (step_s) begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    fsm_r      <= StReseed;
                    idx_r      <= {IdxW{1'b0}};
                    seed_req_r <= 1'b1;
                    cnt_r      <= {CntW{1'b0}};
                end
            endcase
        end
    end

    // Channel state: seed load in RESEED, Galois step in RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < int'(NumCh); c++) begin
                state_r[c] <= DefaultSeed;
            end
        end else begin
            for (int c = 0; c < int'(NumCh); c++) begin
                if (seed_sel_s[c]) begin
                    state_r[c] <= seed_zero_s ? DefaultSeed : seed_i;
                end else if (step_s) begin
                    state_r[c] <= step_val_s[c];
                end
            end
        end
    end

    // Output word register with valid/ready handshake and lockup pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OutDw{1'b0}};
            lockup_r    <= {NumCh{1'b0}};
        end else begin
            if (step_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= out_next_s;
            end else if (out_valid_r && out_ready_i) begin
                out_valid_r <= 1'b0;
            end
            lockup_r <= lockup_next_s;
        end
    end

    assign seed_req_o  = seed_req_r;
    assign seed_idx_o  = idx_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign lockup_o    = lockup_r;

endmodule
